// File: rtl/duty_fader_module.sv
// rtl/duty_fader_module.sv - frame-synchronous RGBW duty fader; optional gamma via DUTY_FADER_GAMMA_EN
module duty_fader_module #(
    parameter int PRESC_DIV = 16,
    parameter int STEP      = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] target0,
    input  logic [7:0] target1,
    input  logic [7:0] target2,
    input  logic [7:0] target3,
    input  logic [7:0] rate,
    input  logic       frame_sync,
    output logic [7:0] duty0,
    output logic [7:0] duty1,
    output logic [7:0] duty2,
    output logic [7:0] duty3,
    output logic       settled
);
    localparam int PW = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
    localparam logic signed [8:0] STEP_P = 9'(STEP);
    localparam logic signed [8:0] STEP_N = -9'(STEP);

    typedef enum logic [2:0] {IDLE, CH0, CH1, CH2, CH3} state_t;

    state_t       state;
    logic [PW-1:0] presc;
    logic [7:0]   rcnt;
    logic [7:0]   cur  [4];
    logic [7:0]   duty [4];
    logic [7:0]   tgt  [4];
    logic         tick;
    logic         step_req;
    logic         all_match;

    assign tgt[0] = target0;
    assign tgt[1] = target1;
    assign tgt[2] = target2;
    assign tgt[3] = target3;
    assign duty0  = duty[0];
    assign duty1  = duty[1];
    assign duty2  = duty[2];
    assign duty3  = duty[3];

    function automatic logic [7:0] shape(input logic [7:0] x);
`ifdef DUTY_FADER_GAMMA_EN
        logic [15:0] sq;
        sq = ({8'd0, x} * {8'd0, x}) + 16'd255;
        return sq[15:8];
`else
        return x;
`endif
    endfunction

    // Clamp to target when within one step so 0 and 255 are hit exactly.
    function automatic logic [7:0] toward(input logic [7:0] c, input logic [7:0] t);
        logic signed [8:0] diff;
        diff = $signed({1'b0, t}) - $signed({1'b0, c});
        if (diff <= STEP_P && diff >= STEP_N) return t;
        else if (diff > 0)                     return c + 8'(STEP);
        else                                   return c - 8'(STEP);
    endfunction

    assign tick     = (presc == PW'(PRESC_DIV - 1));
    assign step_req = tick && (rate != 8'd0) && (rcnt == rate - 8'd1);

    always_comb begin
        all_match = 1'b1;
        for (int n = 0; n < 4; n++) begin
            if (cur[n] != tgt[n] || duty[n] != shape(cur[n])) all_match = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc   <= '0;
            rcnt    <= 8'd0;
            state   <= IDLE;
            settled <= 1'b1;
            for (int n = 0; n < 4; n++) begin
                cur[n]  <= 8'd0;
                duty[n] <= 8'd0;
            end
        end else begin
            presc   <= tick ? '0 : presc + PW'(1);
            settled <= all_match;

            if (rate == 8'd0)
                rcnt <= 8'd0;
            else if (tick)
                rcnt <= (rcnt >= rate - 8'd1) ? 8'd0 : rcnt + 8'd1;

            // Duties sample cur before any same-cycle channel update.
            if (frame_sync) begin
                for (int n = 0; n < 4; n++) duty[n] <= shape(cur[n]);
            end

            if (rate == 8'd0) begin
                state <= IDLE;
                for (int n = 0; n < 4; n++) cur[n] <= tgt[n];
            end else begin
                case (state)
                    IDLE: if (step_req) state <= CH0;
                    CH0: begin cur[0] <= toward(cur[0], tgt[0]); state <= CH1;  end
                    CH1: begin cur[1] <= toward(cur[1], tgt[1]); state <= CH2;  end
                    CH2: begin cur[2] <= toward(cur[2], tgt[2]); state <= CH3;  end
                    CH3: begin cur[3] <= toward(cur[3], tgt[3]); state <= IDLE; end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_duty_fader_module.sv
// tb/tb_duty_fader_module.sv - randomized model-checked bench for duty_fader_module
module tb_duty_fader_module;
    localparam int P = 16;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [3:0][7:0] tgt;
    logic [7:0]      rate;
    logic            frame_sync;
    logic [3:0][7:0] duty_a, duty_b;
    logic            settled_a, settled_b;

    int checks = 0;
    int failures = 0;
    bit chk_en = 0;
    int gcnt = 0;

    always #5 clk = ~clk;

    duty_fader_module #(.PRESC_DIV(P), .STEP(1)) dut_a (
        .clk(clk), .reset(reset),
        .target0(tgt[0]), .target1(tgt[1]), .target2(tgt[2]), .target3(tgt[3]),
        .rate(rate), .frame_sync(frame_sync),
        .duty0(duty_a[0]), .duty1(duty_a[1]), .duty2(duty_a[2]), .duty3(duty_a[3]),
        .settled(settled_a)
    );

    duty_fader_module #(.PRESC_DIV(P), .STEP(7)) dut_b (
        .clk(clk), .reset(reset),
        .target0(tgt[0]), .target1(tgt[1]), .target2(tgt[2]), .target3(tgt[3]),
        .rate(rate), .frame_sync(frame_sync),
        .duty0(duty_b[0]), .duty1(duty_b[1]), .duty2(duty_b[2]), .duty3(duty_b[3]),
        .settled(settled_b)
    );

    // Reference: step events are counted in base ticks; each event sweeps channels 0..3 on
    // the four following cycles; frame_sync copies the shaped level into the duty.
    int m_cur [2][4];
    int m_duty[2][4];
    int m_set [2];
    int m_phase[2];
    int m_cyc, m_ticks;
    int stepv[2] = '{1, 7};
    int r_i, tick_i, stp_i, settle_i;

    function automatic int fshape(input int x);
`ifdef DUTY_FADER_GAMMA_EN
        return (x * x + 255) / 256;
`else
        return x;
`endif
    endfunction

    function automatic int toward(input int c, input int t, input int s);
        int d;
        d = t - c;
        if (d <= s && d >= -s) return t;
        return (d > 0) ? c + s : c - s;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_cyc = 0;
            m_ticks = 0;
            for (int k = 0; k < 2; k++) begin
                m_set[k] = 1;
                m_phase[k] = -1;
                for (int n = 0; n < 4; n++) begin
                    m_cur[k][n] = 0;
                    m_duty[k][n] = 0;
                end
            end
        end else begin
            r_i = int'(rate);
            tick_i = (m_cyc == P - 1) ? 1 : 0;
            m_cyc = (m_cyc + 1) % P;
            stp_i = 0;
            if (r_i == 0) m_ticks = 0;
            else if (tick_i == 1) begin
                if (m_ticks == r_i - 1) begin stp_i = 1; m_ticks = 0; end
                else if (m_ticks > r_i - 1) m_ticks = 0;
                else m_ticks = m_ticks + 1;
            end
            for (int k = 0; k < 2; k++) begin
                settle_i = 1;
                for (int n = 0; n < 4; n++)
                    if (m_cur[k][n] != int'(tgt[n]) || m_duty[k][n] != fshape(m_cur[k][n])) settle_i = 0;
                m_set[k] = settle_i;
                if (frame_sync)
                    for (int n = 0; n < 4; n++) m_duty[k][n] = fshape(m_cur[k][n]);
                if (r_i == 0) begin
                    m_phase[k] = -1;
                    for (int n = 0; n < 4; n++) m_cur[k][n] = int'(tgt[n]);
                end else if (m_phase[k] >= 0) begin
                    m_cur[k][m_phase[k]] = toward(m_cur[k][m_phase[k]], int'(tgt[m_phase[k]]), stepv[k]);
                    m_phase[k] = (m_phase[k] == 3) ? -1 : m_phase[k] + 1;
                end else if (stp_i == 1) begin
                    m_phase[k] = 0;
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int n = 0; n < 4; n++) begin
                check($sformatf("a.duty%0d", n), int'(duty_a[n]), m_duty[0][n]);
                check($sformatf("b.duty%0d", n), int'(duty_b[n]), m_duty[1][n]);
            end
            check("a.settled", int'(settled_a), m_set[0]);
            check("b.settled", int'(settled_b), m_set[1]);
        end
    end

    // fs_per > 0: periodic pulse; 0: none; < 0: random pulses.
    task automatic cyc(input int n, input int fs_per);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #2;
            if (fs_per > 0) frame_sync = ((gcnt % fs_per) == 0);
            else if (fs_per < 0) frame_sync = ($urandom_range(0, 63) == 0);
            else frame_sync = 1'b0;
            gcnt++;
        end
    endtask

    task automatic fs_pulse();
        @(negedge clk); #2; frame_sync = 1'b1;
        @(negedge clk); #2; frame_sync = 1'b0;
    endtask

    task automatic settle_probe();
        @(negedge clk); #1;
    endtask

    initial begin
        tgt = '0;
        rate = 8'd0;
        frame_sync = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        chk_en = 1;
        cyc(3, 0);
        settle_probe();
        check("reset.duty0", int'(duty_a[0]), 0);
        check("reset.settled", int'(settled_a), 1);

        // Basic fade up
        reset = 1'b0;
        tgt[0] = 8'd100;
        rate = 8'd1;
        gcnt = 0;
        cyc(800, 256);
        settle_probe();
        check("fade.mid_settled", int'(settled_a), 0);
        cyc(1200, 256);
        settle_probe();
`ifdef DUTY_FADER_GAMMA_EN
        check("fade.duty0_end", int'(duty_a[0]), 40);
`else
        check("fade.duty0_end", int'(duty_a[0]), 100);
`endif
        check("fade.settled_end", int'(settled_a), 1);

        // Reset in the middle of a ramp
        tgt[0] = 8'd200;
        cyc(300, 256);
        reset = 1'b1;
        cyc(1, 0);
        settle_probe();
        check("midreset.duty0", int'(duty_a[0]), 0);
        check("midreset.settled", int'(settled_a), 1);
        reset = 1'b0;
        cyc(600, 256);

        // Fade down with clamp on the STEP=7 instance
        tgt = '0;
        tgt[2] = 8'd20;
        rate = 8'd0;
        cyc(4, 0);
        rate = 8'd2;
        tgt[2] = 8'd0;
        cyc(400, 64);
        settle_probe();
        check("clamp.b_duty2", int'(duty_b[2]), 0);

        // Bypass
        rate = 8'd0;
        tgt[1] = 8'd10;
        cyc(3, 0);
        fs_pulse();
        cyc(2, 0);
        tgt[1] = 8'd240;
        cyc(5, 0);
        settle_probe();
`ifdef DUTY_FADER_GAMMA_EN
        check("bypass.before_fs", int'(duty_a[1]), 1);
`else
        check("bypass.before_fs", int'(duty_a[1]), 10);
`endif
        fs_pulse();
        settle_probe();
`ifdef DUTY_FADER_GAMMA_EN
        check("bypass.after_fs", int'(duty_a[1]), 225);
`else
        check("bypass.after_fs", int'(duty_a[1]), 240);
`endif

        // Gamma corner points
        tgt[0] = 8'd0; tgt[1] = 8'd1; tgt[2] = 8'd128; tgt[3] = 8'd255;
        cyc(3, 0);
        fs_pulse();
        settle_probe();
        check("gamma.f0", int'(duty_a[0]), 0);
        check("gamma.f1", int'(duty_a[1]), 1);
`ifdef DUTY_FADER_GAMMA_EN
        check("gamma.f128", int'(duty_a[2]), 64);
`else
        check("gamma.f128", int'(duty_a[2]), 128);
`endif
        check("gamma.f255", int'(duty_a[3]), 255);

        // Retarget mid-ramp, then randomized segments
        tgt = '0;
        tgt[3] = 8'd200;
        rate = 8'd1;
        cyc(1950, -1);
        tgt[3] = 8'd50;
        cyc(1000, -1);
        for (int s = 0; s < 40; s++) begin
            for (int n = 0; n < 4; n++) tgt[n] = 8'($urandom_range(0, 255));
            rate = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(1, 3));
            reset = ($urandom_range(0, 9) == 0);
            cyc(1, -1);
            reset = 1'b0;
            cyc($urandom_range(50, 500), -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/duty_fader_module.md
Name: duty_fader_module

Overview:
- Sits between color_wheel_processor and pwm_gen_module.
- Ramps the four PWM duties (R, G, B, W) toward the processor's target duties at a programmable rate, so colour changes fade smoothly instead of stepping.
- Applies new duties to the PWM only on a frame-sync pulse from the PWM counter wrap, so no period ever sees a mid-cycle duty change.

Parameters:
- PRESC_DIV, 16: clk cycles per base tick; must be >= 8.
- STEP, 1: maximum duty change per channel per step event (1..255).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- target0  input  8  red target duty from color_wheel_processor
- target1  input  8  green target duty
- target2  input  8  blue target duty
- target3  input  8  white target duty
- rate  input  8  base ticks per step event; 0 = bypass (no fade)
- frame_sync  input  1  one-cycle pulse at PWM period wrap
- duty0  output  8  red duty to pwm_gen_module
- duty1  output  8  green duty
- duty2  output  8  blue duty
- duty3  output  8  white duty
- settled  output  1  high when every output equals its target

Behaviour:
- Reset (reset=1 at a clk edge):
  - prescaler, rate counter, cur0..3 and duty0..3 cleared to 0.
  - FSM forced to IDLE; settled=1.
  - Applies mid-ramp too; ramp restarts from 0 after release.
- Prescaler:
  - Counts 0..PRESC_DIV-1, emits a base tick on wrap.
  - Free-running, independent of rate.
- Rate counter:
  - Increments on each base tick.
  - When it equals rate-1 (and rate != 0): step_req pulses for one cycle and the counter returns to 0.
  - If rate changes so that count > rate-1, the counter returns to 0 on the next tick without a step.
- FSM states: IDLE, CH0, CH1, CH2, CH3.
  - IDLE -> CH0 on step_req.
  - CH0 -> CH1 -> CH2 -> CH3 -> IDLE, one cycle each.
  - In CHn, curN moves toward targetN sampled in that cycle:
    - diff = targetN - curN, computed as a 9-bit signed value.
    - |diff| <= STEP: curN <= targetN.
    - diff > 0: curN <= curN + STEP.
    - diff < 0: curN <= curN - STEP.
  - No overflow or underflow is possible; 0 and 255 are reached exactly.
  - PRESC_DIV >= 8 guarantees step_req never arrives while the FSM is outside IDLE.
- Bypass (rate=0):
  - FSM held in IDLE; rate counter held at 0.
  - curN <= targetN every cycle.
- Output update:
  - On the cycle frame_sync=1, dutyN <= f(curN), where f is identity unless GAMMA_EN.
  - Update happens on the following edge, so latency from frame_sync is 1 cycle.
  - A frame_sync coinciding with a CHn cycle uses curN before that cycle's update.
  - dutyN is otherwise held.
- settled:
  - Registered; 1 when, for all N, curN == targetN and dutyN == f(curN).
  - Otherwise 0.
  - Recomputed every cycle.
- Target changes mid-ramp: the ramp retargets at the next CHn visit; no restart of counters.

Optional Feature:
- Macro: DUTY_FADER_GAMMA_EN.
- Defined: f(x) = (x*x + 255) >> 8, computed with a 16-bit intermediate. Gives f(0)=0, f(1)=1, f(128)=64, f(255)=255; perceptual brightness correction.
- Not defined: f(x) = x; no multiplier is synthesized.

Test Plan:
- Reset mid-ramp:
  - Stimulus: ramp in progress with cur0=50, target0=200; assert reset for 1 cycle, then frame_sync.
  - Response: duty0..3=0 after reset; settled=1 during reset; ramp then restarts from 0.
- Basic fade up (PRESC_DIV=16, STEP=1, rate=1, frame_sync every 256 cycles, target0 0->100):
  - cur0 rises by 1 every 16 cycles.
  - cur0=100 after 1600 cycles (+/- FSM offset).
  - duty0 tracks cur0 at each frame_sync.
  - settled=0 during the ramp; settled=1 after the first frame_sync following cur0=100.
- Fade down with clamp (STEP=7, rate=2, cur2=20, target2=0):
  - cur2 sequence 20, 13, 6, 0; never wraps to 2xx.
  - Step events occur every 32 cycles.
- Bypass (rate=0, target1 changes 10->240):
  - cur1=240 the next cycle.
  - duty1=240 one cycle after the next frame_sync; unchanged before it.
- Retarget and coincidence:
  - target3 changes 200->50 while cur3=120 and ramping up; cur3 then decreases.
  - frame_sync asserted in the CH3 cycle latches the pre-step value of cur3.
- Gamma (DUTY_FADER_GAMMA_EN defined, rate=0):
  - targets 0/1/128/255 -> duty 0/1/64/255 after frame_sync.
  - Without the macro: duty 0/1/128/255.
